// File: rtl/fifo_axis_pkt.sv
// AXI-Stream synchronous FIFO with tlast framing, occupancy/threshold flags and sticky stall flag.
// Define FIFO_AXIS_PKT_STORE_FWD_EN to enable store-and-forward packet mode.
module fifo_axis_pkt #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_WIDTH = 4,
  parameter int unsigned AF_LEVEL  = DEPTH - 2,
  parameter int unsigned AE_LEVEL  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DATAWIDTH-1:0] s_tdata,
  input  logic                 s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DATAWIDTH-1:0] m_tdata,
  output logic                 m_tlast,
  output logic [PTR_WIDTH:0]   count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 ovf
);

  localparam logic [PTR_WIDTH:0] AfLevel = (PTR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0] AeLevel = (PTR_WIDTH + 1)'(AE_LEVEL);

  logic [DATAWIDTH:0] mem [DEPTH];

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]         stall_cnt_q, stall_cnt_d;
  logic               ovf_q, ovf_d;
  logic               full, empty, wr_en, rd_en, stall;
  logic [DATAWIDTH:0] rd_entry;

  assign full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                 (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign s_tready = ~full;
  assign wr_en    = s_tvalid & s_tready;
  assign rd_en    = m_tvalid & m_tready;
  assign stall    = s_tvalid & ~s_tready;

  // First-word-fall-through: output is the head entry, no output register.
  assign rd_entry = mem[rd_ptr_q[PTR_WIDTH-1:0]];
  assign m_tdata  = rd_entry[DATAWIDTH-1:0];
  assign m_tlast  = rd_entry[DATAWIDTH];

  assign count        = wr_ptr_q - rd_ptr_q;
  assign almost_full  = (count >= AfLevel);
  assign almost_empty = (count <= AeLevel);
  assign ovf          = ovf_q;

`ifdef FIFO_AXIS_PKT_STORE_FWD_EN
  logic [PTR_WIDTH:0] pkt_cnt_q, pkt_cnt_d;
  logic               pkt_inc, pkt_dec;

  assign pkt_inc = wr_en & s_tlast;
  assign pkt_dec = rd_en & m_tlast;

  // The full term releases packets longer than the FIFO so they cannot deadlock.
  assign m_tvalid = ~empty & ((pkt_cnt_q != '0) | full);

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pkt_inc && !pkt_dec) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end else if (pkt_dec && !pkt_inc) begin
      pkt_cnt_d = pkt_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
`else
  assign m_tvalid = ~empty;
`endif

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    if (!stall) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q == 8'hFF) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
    ovf_d = ovf_q | (stall_cnt_d == 8'hFF);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      stall_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      stall_cnt_q <= stall_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage is deliberately not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[PTR_WIDTH-1:0]] <= {s_tlast, s_tdata};
    end
  end

endmodule
